roi_feature_extract: RTL

- Consumes the bounding box and `ofinish` flags produced by the edge-detection stage.
- Once both box axes are complete, it re-reads the binarised frame buffer over the box only.
- It divides the box into a GRID×GRID cell grid and emits one feature bit per cell (cell is "black" when its black-pixel count ≥ MIN_BLACK).
- The output bit-vector feeds the digit classifier.

---
 rtl/roi_feature_extract.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/roi_feature_extract.sv
// Re-reads the binarised frame over a detected bounding box and reduces it to a
// GRID x GRID black/white feature vector for the digit classifier.
//
// state  | meaning
// IDLE   | waiting for ifinish to rise to 2'b11
// CHECK  | clamp and validate the box, load scan start address
// SCAN   | one frame-buffer read per enabled cycle, raster order
// DRAIN  | last read in flight, final band commit pending
// DONE   | ovalid pulse
module roi_feature_extract #(
    parameter int IMG_W     = 640,
    parameter int IMG_H     = 480,
    parameter int GRID      = 8,
    parameter int MIN_BLACK = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [19:0]            iRow,
    input  logic [19:0]            iCol,
    input  logic [1:0]             ifinish,
    output logic [18:0]            oaddr,
    output logic                   ord_en,
    input  logic [9:0]             idata,
    output logic [GRID*GRID-1:0]   ofeature,
    output logic                   ovalid,
    output logic                   oerr,
    output logic                   obusy
);
    localparam int CW = (GRID > 1) ? $clog2(GRID) : 1;
    localparam logic [10:0]   IMG_W11 = 11'(IMG_W);
    localparam logic [10:0]   IMG_H11 = 11'(IMG_H);
    localparam logic [10:0]   GRID11  = 11'(GRID);
    localparam logic [18:0]   IMG_W19 = 19'(IMG_W);
    localparam logic [15:0]   MINB    = 16'(MIN_BLACK);
    localparam logic [CW-1:0] ONE_C   = 1;

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_SCAN, S_DRAIN, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [1:0]           fin_prev_q, fin_prev_d;
    logic [10:0]          w_q, w_d, h_q, h_d;
    logic [10:0]          col_q, col_d, row_q, row_d;
    logic [10:0]          acc_x_q, acc_x_d, acc_y_q, acc_y_d;
    logic [CW-1:0]        cx_q, cx_d, cy_q, cy_d;
    logic [18:0]          oaddr_q, oaddr_d, row_start_q, row_start_d;
    logic                 rd_dly_q, rd_dly_d, eob_dly_q, eob_dly_d;
    logic [CW-1:0]        cx_dly_q, cx_dly_d, cy_dly_q, cy_dly_d;
    logic                 commit_q, commit_d;
    logic [CW-1:0]        commit_cy_q, commit_cy_d;
    logic [15:0]          cnt_q [GRID];
    logic [15:0]          cnt_d [GRID];
    logic [GRID*GRID-1:0] ofeature_q, ofeature_d;
    logic                 oerr_q, oerr_d;

    // Box clamp; the top/left wrap case comes from an underflowed coordinate.
    logic [10:0] top_c, bot_c, left_c, right_c, box_w, box_h, ax, ay;
    logic [18:0] start_addr;
    logic        box_bad, last_col;
    logic [15:0] base;

    always_comb begin
        top_c   = ({1'b0, iRow[9:0]}   >= IMG_H11) ? 11'd0 : {1'b0, iRow[9:0]};
        bot_c   = ({1'b0, iRow[19:10]} >= IMG_H11) ? IMG_H11 - 11'd1 : {1'b0, iRow[19:10]};
        left_c  = ({1'b0, iCol[9:0]}   >= IMG_W11) ? 11'd0 : {1'b0, iCol[9:0]};
        right_c = ({1'b0, iCol[19:10]} >= IMG_W11) ? IMG_W11 - 11'd1 : {1'b0, iCol[19:10]};
        box_w   = right_c - left_c + 11'd1;
        box_h   = bot_c - top_c + 11'd1;
        box_bad = (top_c > bot_c) || (left_c > right_c) || (box_w < GRID11) || (box_h < GRID11);
        start_addr = 19'(top_c) * IMG_W19 + 19'(left_c);
        last_col = (col_q == w_q - 11'd1);
        ax = acc_x_q + GRID11;
        ay = acc_y_q + GRID11;
    end

    always_comb begin
        state_d     = state_q;
        fin_prev_d  = ifinish;
        w_d         = w_q;
        h_d         = h_q;
        col_d       = col_q;
        row_d       = row_q;
        acc_x_d     = acc_x_q;
        acc_y_d     = acc_y_q;
        cx_d        = cx_q;
        cy_d        = cy_q;
        oaddr_d     = oaddr_q;
        row_start_d = row_start_q;
        rd_dly_d    = 1'b0;
        eob_dly_d   = 1'b0;
        cx_dly_d    = cx_q;
        cy_dly_d    = cy_q;
        commit_d    = eob_dly_q;
        commit_cy_d = cy_dly_q;
        ofeature_d  = ofeature_q;
        oerr_d      = oerr_q;
        base        = '0;

        // Commit clears the band counters while the next band's first pixel may
        // already be landing, so the clear and the increment share one update.
        for (int k = 0; k < GRID; k++) begin
            base = commit_q ? 16'd0 : cnt_q[k];
            if (rd_dly_q && (idata == 10'd0) && (cx_dly_q == CW'(k)) && (base != 16'hFFFF))
                cnt_d[k] = base + 16'd1;
            else
                cnt_d[k] = base;
        end
        for (int b = 0; b < GRID; b++)
            for (int k = 0; k < GRID; k++)
                if (commit_q && (commit_cy_q == CW'(b)))
                    ofeature_d[b*GRID+k] = (cnt_q[k] >= MINB);

        unique case (state_q)
            S_IDLE: begin
                if (en && (ifinish == 2'b11) && (fin_prev_q != 2'b11))
                    state_d = S_CHECK;
            end
            S_CHECK: begin
                w_d = box_w;
                h_d = box_h;
                if (box_bad) begin
                    state_d    = S_DONE;
                    oerr_d     = 1'b1;
                    ofeature_d = '0;
                end else begin
                    state_d     = S_SCAN;
                    oaddr_d     = start_addr;
                    row_start_d = start_addr;
                    col_d       = '0;
                    row_d       = '0;
                    acc_x_d     = '0;
                    acc_y_d     = '0;
                    cx_d        = '0;
                    cy_d        = '0;
                end
            end
            S_SCAN: begin
                if (en) begin
                    rd_dly_d  = 1'b1;
                    eob_dly_d = last_col && (ay >= h_q);
                    if (last_col) begin
                        col_d       = '0;
                        acc_x_d     = '0;
                        cx_d        = '0;
                        row_d       = row_q + 11'd1;
                        row_start_d = row_start_q + IMG_W19;
                        oaddr_d     = row_start_q + IMG_W19;
                        if (ay >= h_q) begin
                            acc_y_d = ay - h_q;
                            cy_d    = cy_q + ONE_C;
                        end else begin
                            acc_y_d = ay;
                        end
                        if (row_q == h_q - 11'd1)
                            state_d = S_DRAIN;
                    end else begin
                        col_d   = col_q + 11'd1;
                        oaddr_d = oaddr_q + 19'd1;
                        if (ax >= w_q) begin
                            acc_x_d = ax - w_q;
                            cx_d    = cx_q + ONE_C;
                        end else begin
                            acc_x_d = ax;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (commit_q && !rd_dly_q) begin
                    state_d = S_DONE;
                    oerr_d  = 1'b0;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            fin_prev_q  <= 2'b11;
            w_q         <= '0;
            h_q         <= '0;
            col_q       <= '0;
            row_q       <= '0;
            acc_x_q     <= '0;
            acc_y_q     <= '0;
            cx_q        <= '0;
            cy_q        <= '0;
            oaddr_q     <= '0;
            row_start_q <= '0;
            rd_dly_q    <= 1'b0;
            eob_dly_q   <= 1'b0;
            cx_dly_q    <= '0;
            cy_dly_q    <= '0;
            commit_q    <= 1'b0;
            commit_cy_q <= '0;
            ofeature_q  <= '0;
            oerr_q      <= 1'b0;
            for (int k = 0; k < GRID; k++) cnt_q[k] <= '0;
        end else begin
            state_q     <= state_d;
            fin_prev_q  <= fin_prev_d;
            w_q         <= w_d;
            h_q         <= h_d;
            col_q       <= col_d;
            row_q       <= row_d;
            acc_x_q     <= acc_x_d;
            acc_y_q     <= acc_y_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            oaddr_q     <= oaddr_d;
            row_start_q <= row_start_d;
            rd_dly_q    <= rd_dly_d;
            eob_dly_q   <= eob_dly_d;
            cx_dly_q    <= cx_dly_d;
            cy_dly_q    <= cy_dly_d;
            commit_q    <= commit_d;
            commit_cy_q <= commit_cy_d;
            ofeature_q  <= ofeature_d;
            oerr_q      <= oerr_d;
            for (int k = 0; k < GRID; k++) cnt_q[k] <= cnt_d[k];
        end
    end

    assign oaddr    = oaddr_q;
    assign ord_en   = (state_q == S_SCAN) && en;
    assign ofeature = ofeature_q;
    assign ovalid   = (state_q == S_DONE);
    assign oerr     = oerr_q;
    assign obusy    = (state_q != S_IDLE);
endmodule
